// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared encodings, BTB entry type and counter helper for the branch predictor
// Contents: branch-type encoding from EX, 2-bit counter states, BTB kind
// encoding, BTB entry struct, saturating counter step, bType-to-kind mapping.
package bp_pkg;

    typedef enum logic [2:0] {
        BT_NONE   = 3'b000,
        BT_JUMP   = 3'b001,
        BT_BRANCH = 3'b010,
        BT_CALL   = 3'b011,
        BT_RET    = 3'b100
    } btype_e;

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    typedef enum logic [1:0] {
        K_BRANCH = 2'b00,
        K_JUMP   = 2'b01,
        K_CALL   = 2'b10,
        K_RET    = 2'b11
    } btb_kind_e;

    // Tag is stored zero-extended to 30 bits so the struct does not depend on
    // the BTB size; only PC[31:log2(entries)+2] is ever placed in it.
    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [31:0] target;
        btb_kind_e   kind;
    } btb_entry_t;

    function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic taken);
        if (taken) begin
            return (c == CNT_ST) ? CNT_ST : c + 2'd1;
        end
        return (c == CNT_SNT) ? CNT_SNT : c - 2'd1;
    endfunction

    function automatic btb_kind_e kind_of(input logic [2:0] bt);
        case (bt)
            BT_JUMP: return K_JUMP;
            BT_CALL: return K_CALL;
            BT_RET:  return K_RET;
            default: return K_BRANCH;
        endcase
    endfunction

endpackage

// File: rtl/bp_ras.sv
// rtl/bp_ras.sv - circular return address stack with saturating occupancy
// Ports: clk, rst (async active-high), clr (sync clear), push/pop strobes,
// push_data (32-bit link), top (most recent entry), empty.
// A push when full overwrites the oldest entry; a pop when empty does nothing.
module bp_ras
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] push_data,
    output logic [31:0] top,
    output logic        empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [31:0]      stack [DEPTH];
    logic [PTR_W-1:0] ptr;      // next slot to write
    logic [PTR_W-1:0] ptr_inc;
    logic [PTR_W-1:0] ptr_dec;
    logic [CNT_W-1:0] count;

    assign ptr_inc = (ptr == LAST) ? '0 : ptr + PTR_W'(1);
    assign ptr_dec = (ptr == '0) ? LAST : ptr - PTR_W'(1);
    assign top     = stack[ptr_dec];
    assign empty   = (count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stack[i] <= '0;
            end
            ptr   <= '0;
            count <= '0;
        end else if (clr) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            stack[ptr] <= push_data;
            ptr        <= ptr_inc;
            if (count != FULL) begin
                count <= count + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            ptr   <= ptr_dec;
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/gshare_ras_predictor.sv
// rtl/gshare_ras_predictor.sv - gshare direction predictor with BTB and return address stack
// Ports: clk, rst (async active-high), upd_en, flush;
// IF side: IF_PC in, IF_pTaken / IF_pTarget out (combinational);
// EX side: EX_bType, EX_rTaken, EX_PC, EX_bTarget, EX_linkPC, EX_pTaken, EX_pTarget;
// perf_branches / perf_mispred saturating event counters.
module gshare_ras_predictor
    import bp_pkg::*;
#(
    parameter int BTB_ENTRIES = 32,
    parameter int PHT_ENTRIES = 64,
    parameter int RAS_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        upd_en,
    input  logic        flush,
    input  logic [31:0] IF_PC,
    output logic        IF_pTaken,
    output logic [31:0] IF_pTarget,
    input  logic [2:0]  EX_bType,
    input  logic        EX_rTaken,
    input  logic [31:0] EX_PC,
    input  logic [31:0] EX_bTarget,
    input  logic [31:0] EX_linkPC,
    input  logic        EX_pTaken,
    input  logic [31:0] EX_pTarget,
    output logic [31:0] perf_branches,
    output logic [31:0] perf_mispred
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int GHR_W = $clog2(PHT_ENTRIES);

    btb_entry_t       btb [BTB_ENTRIES];
    logic [1:0]       pht [PHT_ENTRIES];
    logic [GHR_W-1:0] ghr;

    logic [31:0] ras_top;
    logic        ras_empty;

    function automatic logic [29:0] pc_tag(input logic [31:0] pc);
        return 30'(pc[31:IDX_W+2]);
    endfunction

    // ---------------- IF lookup ----------------
    logic [IDX_W-1:0] if_bidx;
    logic [GHR_W-1:0] if_pidx;
    btb_entry_t       if_ent;
    logic             if_hit;

    assign if_bidx = IF_PC[IDX_W+1:2];
    assign if_pidx = IF_PC[GHR_W+1:2] ^ ghr;
    assign if_ent  = btb[if_bidx];
    assign if_hit  = if_ent.valid && (if_ent.tag == pc_tag(IF_PC));

    always_comb begin
        IF_pTaken  = 1'b0;
        IF_pTarget = '0;
        if (if_hit) begin
            IF_pTarget = if_ent.target;
            case (if_ent.kind)
                K_BRANCH: IF_pTaken = pht[if_pidx][1];
                K_RET: begin
                    IF_pTaken = 1'b1;
                    if (!ras_empty) begin
                        IF_pTarget = ras_top;
                    end
                end
                default:  IF_pTaken = 1'b1;
            endcase
        end
    end

    // ---------------- EX resolution ----------------
    logic [IDX_W-1:0] ex_bidx;
    logic [GHR_W-1:0] ex_pidx;
    btb_entry_t       ex_ent;
    logic             ex_hit;
    logic             ex_cf;
    logic             ex_known;
    logic             ex_is_br;
    logic             ex_act_taken;
    logic             ex_mispred;
    logic             ex_do;
    logic [GHR_W-1:0] ghr_next;
    logic             unused_pc_bits;

    assign ex_bidx  = EX_PC[IDX_W+1:2];
    assign ex_pidx  = EX_PC[GHR_W+1:2] ^ ghr;
    assign ex_ent   = btb[ex_bidx];
    assign ex_hit   = ex_ent.valid && (ex_ent.tag == pc_tag(EX_PC));
    assign ex_cf    = (EX_bType != BT_NONE);
    assign ex_is_br = (EX_bType == BT_BRANCH);
    assign ex_known = (EX_bType == BT_JUMP) || (EX_bType == BT_BRANCH) ||
                      (EX_bType == BT_CALL) || (EX_bType == BT_RET);

    // Unconditional kinds are always taken; only conditional branches carry a direction.
    assign ex_act_taken = ex_is_br ? EX_rTaken : 1'b1;
    assign ex_mispred   = ex_cf && ((EX_pTaken != ex_act_taken) ||
                                    (ex_act_taken && (EX_pTarget != EX_bTarget)));
    assign ex_do        = upd_en && !flush;

    // Size cast drops the oldest history bit; also covers the 1-bit history case.
    assign ghr_next = GHR_W'({ghr, EX_rTaken});

    assign unused_pc_bits = ^{IF_PC[1:0], EX_PC[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb[i] <= '0;
            end
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht[i] <= CNT_WT;
            end
            ghr           <= '0;
            perf_branches <= '0;
            perf_mispred  <= '0;
        end else if (flush) begin
            // Only valid bits are cleared; stale tag/target are unreachable once invalid.
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb[i].valid <= 1'b0;
            end
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht[i] <= CNT_WT;
            end
            ghr <= '0;
        end else if (upd_en) begin
            if (ex_known) begin
                if (!ex_hit) begin
                    btb[ex_bidx] <= '{valid:  1'b1,
                                      tag:    pc_tag(EX_PC),
                                      target: EX_bTarget,
                                      kind:   kind_of(EX_bType)};
                end else if (ex_ent.target != EX_bTarget) begin
                    btb[ex_bidx].target <= EX_bTarget;
                end
            end
            if (ex_is_br) begin
                // A freshly allocated branch starts weak in its resolved direction.
                if (!ex_hit) begin
                    pht[ex_pidx] <= EX_rTaken ? CNT_WT : CNT_WNT;
                end else begin
                    pht[ex_pidx] <= ctr_step(pht[ex_pidx], EX_rTaken);
                end
                ghr <= ghr_next;
            end
            if (ex_cf && (perf_branches != '1)) begin
                perf_branches <= perf_branches + 32'd1;
            end
            if (ex_mispred && (perf_mispred != '1)) begin
                perf_mispred <= perf_mispred + 32'd1;
            end
        end
    end

    bp_ras #(
        .DEPTH(RAS_DEPTH)
    ) u_ras (
        .clk      (clk),
        .rst      (rst),
        .clr      (flush),
        .push     (ex_do && (EX_bType == BT_CALL)),
        .pop      (ex_do && (EX_bType == BT_RET)),
        .push_data(EX_linkPC),
        .top      (ras_top),
        .empty    (ras_empty)
    );

endmodule

// File: doc/gshare_ras_predictor.md
GSHARE_RAS_PREDICTOR -- requirements
Module: gshare_ras_predictor

Interface
REQ-001 Parameter BTB_ENTRIES, default 32: direct-mapped BTB entries, power of two, >=2.
REQ-002 Parameter PHT_ENTRIES, default 64: 2-bit counters, power of two, >=2; GHR_W = log2(PHT_ENTRIES).
REQ-003 Parameter RAS_DEPTH, default 4: return address stack entries, >=2.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 upd_en  input  1  update enable; high only when IF and MEM stages complete (no stall).
REQ-007 flush  input  1  interrupt flush; clears all predictor state.
REQ-008 IF_PC  input  32  fetch PC.
REQ-009 IF_pTaken  output  1  predicted taken.
REQ-010 IF_pTarget  output  32  predicted target.
REQ-011 EX_bType  input  3  000 none, 001 jump, 010 cond branch, 011 call, 100 return.
REQ-012 EX_rTaken  input  1  resolved direction (ignored unless type 010).
REQ-013 EX_PC / EX_bTarget / EX_linkPC  input  32 each  resolving PC, resolved target, PC+4.
REQ-014 EX_pTaken / EX_pTarget  input  1 / 32  prediction made for this instruction, piped from IF.
REQ-015 perf_branches / perf_mispred  output  32 each  resolved control-flow count, mispredict count.

Function
REQ-016 BTB entry SHALL hold valid, tag (PC[31:log2(BTB_ENTRIES)+2]), 32-bit target, 2-bit kind (branch, jump, call, return); index PC[log2(BTB_ENTRIES)+1:2].
REQ-017 PHT index SHALL be PC[GHR_W+1:2] XOR GHR, for both IF lookup and EX update.
REQ-018 Counters SHALL be 2-bit saturating: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; predict taken iff bit 1 set.
REQ-019 IF prediction combinational: miss -> pTaken 0; hit branch -> counter bit 1, BTB target; hit jump/call -> taken, BTB target; hit return -> taken, RAS top if RAS non-empty else BTB target.
REQ-020 All EX updates SHALL occur only on a clock edge with upd_en=1 and flush=0.
REQ-021 Type 010: counter at EX index increments if taken else decrements, saturating; GHR <= {GHR[GHR_W-2:0], EX_rTaken}.
REQ-022 Type 010 BTB miss: allocate entry, counter written 10 if taken else 01 (overrides REQ-021 counter step).
REQ-023 Types 001/011/100 BTB miss: allocate entry with kind; any hit whose stored target differs from EX_bTarget SHALL overwrite target (all kinds).
REQ-024 Type 011 SHALL push EX_linkPC; full RAS SHALL overwrite oldest entry (circular), occupancy saturating at RAS_DEPTH.
REQ-025 Type 100 SHALL pop; pop on empty SHALL be a no-op, occupancy stays 0.
REQ-026 GHR and RAS SHALL update non-speculatively (EX only); no IF-side state change.
REQ-027 Mispredict for type != 000: (EX_pTaken != actual taken) or (actual taken and EX_pTarget != EX_bTarget); actual taken = EX_rTaken for 010, 1 otherwise.
REQ-028 perf_branches increments per type != 000, perf_mispred per mispredict; both saturate at 32'hFFFF_FFFF.
REQ-029 flush SHALL, on the next edge, invalidate BTB, set counters to 10, clear GHR and RAS; perf counters SHALL hold; flush has priority over update.
REQ-030 Same-index IF read and EX write in one cycle: IF sees pre-update value (no bypass).

Reset
REQ-031 rst SHALL immediately set: BTB invalid (tag/target/kind 0), counters 10, GHR 0, RAS occupancy 0 and pointer 0, perf counters 0; hence IF_pTaken=0, IF_pTarget=0.
REQ-032 rst asserted mid-update SHALL discard that update entirely.

Structure
REQ-033 Package bp_pkg SHALL hold the bType encoding, counter state constants, BTB kind encoding and the BTB entry struct.
REQ-034 RAS SHALL be sub-module bp_ras (params DEPTH; ports clk, rst, clr, push, pop, push_data, top, empty).

Verification
REQ-035 Branch at 0x100, taken x3 with GHR held constant via isolation -> counter 10->11->11; after third, IF_PC=0x100 gives pTaken=1, target 0x200.
REQ-036 Call at 0x40 (link 0x44) then return at 0x80 -> IF_PC=0x80 predicts taken, target 0x44; second return with empty RAS -> BTB target.
REQ-037 RAS_DEPTH=4, 5 calls links 0x10..0x50 -> pops yield 0x50,0x40,0x30,0x20 then empty (0x10 lost).
REQ-038 flush with valid BTB at 0x100 -> next cycle IF_PC=0x100 pTaken=0; perf counters unchanged.
REQ-039 upd_en=0 with EX type 010 -> no BTB/PHT/GHR/perf change.
REQ-040 EX_pTaken=1, EX_pTarget=0x200, resolved taken to 0x300 -> perf_mispred +1, BTB target becomes 0x300.
